// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_interface between NUM_REQ requesters, with a busy watchdog.
module spi_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SELW    = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data_out,
    input  logic [8*NUM_REQ-1:0]  req_write_bits,
    input  logic [8*NUM_REQ-1:0]  req_read_bits,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_error,
    output logic [SELW-1:0]       spi_sel,
    output logic [31:0]           spi_data_out,
    output logic [7:0]            spi_write_bits,
    output logic [7:0]            spi_read_bits,
    output logic                  spi_request,
    input  logic                  spi_busy,
    input  logic [31:0]           spi_data_in
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
    localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);
    state_t state, state_nx;
    logic [SELW-1:0] rr, pick, idx;
    logic [15:0] cnt;
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TLIM);
    assign spi_request = state == ISSUE;
    assign req_ready = spi_request ? NUM_REQ'(1) << spi_sel : '0;
    // Pick the first valid requester at or above rr; scanning offsets downward lets the smallest offset win.
    always_comb begin
        pick = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = SELW'((int'(rr) + k) % NUM_REQ);
            if (req_valid[idx]) pick = idx;
        end
    end
    // Next-state logic; the watchdog only fires while busy is still high.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = |req_valid ? ISSUE : IDLE;
            ISSUE: state_nx = WAIT;
            WAIT:  state_nx = !spi_busy ? IDLE : timeout_hit ? DRAIN : WAIT;
            DRAIN: state_nx = !spi_busy ? IDLE : DRAIN;
        endcase
    end
    // State register.
    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
    // Latch the winner, advance the pointer, run the watchdog and register the response strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr             <= '0;
            spi_sel        <= '0;
            spi_data_out   <= '0;
            spi_write_bits <= '0;
            spi_read_bits  <= '0;
            cnt            <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: if (|req_valid) begin
                    spi_sel        <= pick;
                    spi_data_out   <= req_data_out[32*pick +: 32];
                    spi_write_bits <= req_write_bits[8*pick +: 8];
                    spi_read_bits  <= req_read_bits[8*pick +: 8];
                end
                ISSUE: begin
                    rr  <= (spi_sel == SELW'(NUM_REQ - 1)) ? '0 : spi_sel + 1'b1;
                    cnt <= '0;
                end
                WAIT: if (!spi_busy) begin
                    rsp_valid <= NUM_REQ'(1) << spi_sel;
                    rsp_data  <= spi_data_in;
                    rsp_error <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_valid <= NUM_REQ'(1) << spi_sel;
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scoreboard bench for spi_arbiter with a behavioural spi_interface model.
module tb_spi_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req_valid = '0;
    logic [127:0] req_data_out = '0;
    logic [31:0] req_write_bits = '0;
    logic [31:0] req_read_bits = '0;
    logic [3:0] req_ready, rsp_valid;
    logic [31:0] rsp_data, spi_data_out, spi_data_in;
    logic rsp_error, spi_request, spi_busy;
    logic [1:0] spi_sel;
    logic [7:0] spi_write_bits, spi_read_bits;

    spi_arbiter #(.NUM_REQ(4), .SELW(2), .TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data_out(req_data_out),
        .req_write_bits(req_write_bits), .req_read_bits(req_read_bits), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .spi_sel(spi_sel),
        .spi_data_out(spi_data_out), .spi_write_bits(spi_write_bits), .spi_read_bits(spi_read_bits),
        .spi_request(spi_request), .spi_busy(spi_busy), .spi_data_in(spi_data_in)
    );

    always #5 clk = ~clk;

    // SPI model: busy for write+read bits plus one cycle, read-back word present only in the completion cycle.
    logic [8:0] left;
    logic stuck = 1'b0;
    logic [31:0] ret_tab [4];
    always @(posedge clk) begin
        spi_data_in <= '0;
        if (reset) begin
            spi_busy <= 1'b0;
            left <= '0;
        end else if (spi_request) begin
            spi_busy <= 1'b1;
            left <= 9'(spi_write_bits) + 9'(spi_read_bits);
        end else if (spi_busy && !stuck) begin
            if (left == 0) begin
                spi_busy <= 1'b0;
                spi_data_in <= ret_tab[spi_sel];
            end else left <= left - 1'b1;
        end
    end

    typedef struct {logic [3:0] vec; logic [1:0] sel; logic req; logic [31:0] d; logic [7:0] wb; logic [7:0] rb; int c;} grant_t;
    typedef struct {logic [3:0] vec; logic [31:0] d; logic e; int c;} rsp_t;
    grant_t obs_g[$];
    rsp_t obs_r[$];
    logic [3:0] exp_g[$];
    rsp_t exp_r[$];
    int cyc = 0;
    int pulses = 0;
    int gi = 0, ri = 0;
    int total = 0, bad = 0;
    logic auto_drop = 1'b1;
    logic [3:0] e_g;
    rsp_t e_r, o_r;

    always @(posedge clk) cyc <= cyc + 1;
    // Monitor: record every grant and response with the cycle it was seen in.
    always @(negedge clk) begin
        if (spi_request) pulses <= pulses + 1;
        if (req_ready != 0 || spi_request)
            obs_g.push_back('{req_ready, spi_sel, spi_request, spi_data_out, spi_write_bits, spi_read_bits, cyc});
        if (rsp_valid != 0) obs_r.push_back('{rsp_valid, rsp_data, rsp_error, cyc});
    end

    task automatic step();
        @(negedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~req_ready;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        stuck = 1'b0;
        auto_drop = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_g.delete();
        exp_r.delete();
        gi = obs_g.size();
        ri = obs_r.size();
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [7:0] wb, input logic [7:0] rb, input logic [31:0] ret);
        req_data_out[32*i +: 32] = d;
        req_write_bits[8*i +: 8] = wb;
        req_read_bits[8*i +: 8] = rb;
        ret_tab[i] = ret;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) ret_tab[i] = 32'hDEAD0000 + i;
        step();
        step();
        total++;
        if ({req_ready, rsp_valid, spi_request, spi_sel, spi_data_out, spi_write_bits, spi_read_bits, rsp_data, rsp_error} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b rsp=%b req=%b sel=%0d dout=%h wb=%0d rb=%0d rdata=%h err=%b, required all 0",
                     req_ready, rsp_valid, spi_request, spi_sel, spi_data_out, spi_write_bits, spi_read_bits, rsp_data, rsp_error);
        end
        reset = 1'b0;
        step();
        step();
        total++;
        if ({req_ready, spi_request, rsp_valid} !== '0) begin
            bad++;
            $display("FAIL reset_idle: got ready=%b req=%b rsp=%b with no request, required 0", req_ready, spi_request, rsp_valid);
        end
    endtask

    task automatic test_single();
        int t0, p0;
        do_reset();
        set_req(2, 32'h8A000000, 8'd8, 8'd8, 32'h000000A5);
        t0 = cyc;
        p0 = pulses;
        req_valid = 4'b0100;
        exp_g.push_back(4'b0100);
        exp_r.push_back('{4'b0100, 32'h000000A5, 1'b0, t0 + 20});
        for (int i = 0; i < 100 && obs_r.size() <= ri; i++) step();
        repeat (8) step();
        total++;
        if (obs_g.size() <= gi) begin
            bad++;
            $display("FAIL single_fields: no grant seen, required one");
        end else if (obs_g[gi].sel !== 2'd2 || obs_g[gi].d !== 32'h8A000000 || obs_g[gi].wb !== 8'd8 || obs_g[gi].rb !== 8'd8 || obs_g[gi].c != t0 + 1) begin
            bad++;
            $display("FAIL single_fields: got sel=%0d dout=%h wb=%0d rb=%0d cyc=%0d, required sel=2 dout=8a000000 wb=8 rb=8 cyc=%0d",
                     obs_g[gi].sel, obs_g[gi].d, obs_g[gi].wb, obs_g[gi].rb, obs_g[gi].c, t0 + 1);
        end
        total++;
        if (pulses - p0 != 1) begin
            bad++;
            $display("FAIL single_pulses: got %0d spi_request cycles, required 1", pulses - p0);
        end
        while (exp_g.size() > 0) begin
            e_g = exp_g.pop_front();
            total++;
            if (gi >= obs_g.size()) begin bad++; $display("FAIL single_grant: missing, required %b", e_g); end
            else begin
                if (obs_g[gi].vec !== e_g || obs_g[gi].req !== 1'b1) begin
                    bad++;
                    $display("FAIL single_grant: got ready=%b request=%b, required ready=%b request=1", obs_g[gi].vec, obs_g[gi].req, e_g);
                end
                gi++;
            end
        end
        while (exp_r.size() > 0) begin
            e_r = exp_r.pop_front();
            total++;
            if (ri >= obs_r.size()) begin bad++; $display("FAIL single_rsp: missing, required rsp=%b data=%h", e_r.vec, e_r.d); end
            else begin
                o_r = obs_r[ri];
                ri++;
                if (o_r.vec !== e_r.vec || o_r.d !== e_r.d || o_r.e !== e_r.e || (e_r.c >= 0 && o_r.c != e_r.c)) begin
                    bad++;
                    $display("FAIL single_rsp: got rsp=%b data=%h err=%b cyc=%0d, required rsp=%b data=%h err=%b cyc=%0d",
                             o_r.vec, o_r.d, o_r.e, o_r.c, e_r.vec, e_r.d, e_r.e, e_r.c);
                end
            end
        end
    endtask

    task automatic test_rotation();
        int p0;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 32'h11111111 * (i + 1), 8'(i + 1), 8'd1, 32'hC0DE0000 + i);
        for (int k = 0; k < 5; k++) begin
            exp_g.push_back(4'(1 << (k % 4)));
            exp_r.push_back('{4'(1 << (k % 4)), 32'hC0DE0000 + (k % 4), 1'b0, -1});
        end
        auto_drop = 1'b0;
        p0 = pulses;
        req_valid = 4'b1111;
        for (int i = 0; i < 400 && obs_r.size() - ri < 5; i++) begin
            step();
            if (obs_g.size() - gi >= 5) req_valid = '0;
        end
        repeat (10) step();
        total++;
        if (pulses - p0 != 5 || obs_g.size() - gi != 5) begin
            bad++;
            $display("FAIL rotation_count: got %0d pulses and %0d grants, required 5 and 5", pulses - p0, obs_g.size() - gi);
        end
        for (int k = 0; k < 5 && gi + k < obs_g.size(); k++) begin
            total++;
            if (obs_g[gi + k].sel !== 2'(k % 4) || obs_g[gi + k].d !== 32'h11111111 * ((k % 4) + 1)) begin
                bad++;
                $display("FAIL rotation_fields%0d: got sel=%0d dout=%h, required sel=%0d dout=%h",
                         k, obs_g[gi + k].sel, obs_g[gi + k].d, k % 4, 32'h11111111 * ((k % 4) + 1));
            end
        end
        while (exp_g.size() > 0) begin
            e_g = exp_g.pop_front();
            total++;
            if (gi >= obs_g.size()) begin bad++; $display("FAIL rotation_grant: missing, required %b", e_g); end
            else begin
                if (obs_g[gi].vec !== e_g || obs_g[gi].req !== 1'b1) begin
                    bad++;
                    $display("FAIL rotation_grant: got ready=%b request=%b, required ready=%b request=1", obs_g[gi].vec, obs_g[gi].req, e_g);
                end
                gi++;
            end
        end
        while (exp_r.size() > 0) begin
            e_r = exp_r.pop_front();
            total++;
            if (ri >= obs_r.size()) begin bad++; $display("FAIL rotation_rsp: missing, required rsp=%b data=%h", e_r.vec, e_r.d); end
            else begin
                o_r = obs_r[ri];
                ri++;
                if (o_r.vec !== e_r.vec || o_r.d !== e_r.d || o_r.e !== e_r.e) begin
                    bad++;
                    $display("FAIL rotation_rsp: got rsp=%b data=%h err=%b, required rsp=%b data=%h err=%b", o_r.vec, o_r.d, o_r.e, e_r.vec, e_r.d, e_r.e);
                end
            end
        end
        auto_drop = 1'b1;
    endtask

    task automatic test_skip();
        do_reset();
        set_req(1, 32'h01000000, 8'd3, 8'd0, 32'h00001111);
        set_req(3, 32'h03000000, 8'd2, 8'd2, 32'h00003333);
        req_valid = 4'b0010;
        exp_g.push_back(4'b0010);
        exp_r.push_back('{4'b0010, 32'h00001111, 1'b0, -1});
        for (int i = 0; i < 100 && obs_r.size() - ri < 1; i++) step();
        req_valid = 4'b1010;
        exp_g.push_back(4'b1000);
        exp_g.push_back(4'b0010);
        exp_r.push_back('{4'b1000, 32'h00003333, 1'b0, -1});
        exp_r.push_back('{4'b0010, 32'h00001111, 1'b0, -1});
        for (int i = 0; i < 200 && obs_r.size() - ri < 3; i++) step();
        repeat (10) step();
        total++;
        if (obs_r.size() - ri < 2 || obs_g.size() - gi < 3 || obs_r[ri + 1].c >= obs_g[gi + 2].c) begin
            bad++;
            $display("FAIL skip_order: response 2 not seen before grant 3 (%0d rsps, %0d grants), required rsp first", obs_r.size() - ri, obs_g.size() - gi);
        end
        while (exp_g.size() > 0) begin
            e_g = exp_g.pop_front();
            total++;
            if (gi >= obs_g.size()) begin bad++; $display("FAIL skip_grant: missing, required %b", e_g); end
            else begin
                if (obs_g[gi].vec !== e_g) begin
                    bad++;
                    $display("FAIL skip_grant: got ready=%b, required %b", obs_g[gi].vec, e_g);
                end
                gi++;
            end
        end
        total++;
        if (obs_g.size() != gi) begin bad++; $display("FAIL skip_extra: got %0d extra grants, required 0", obs_g.size() - gi); end
        while (exp_r.size() > 0) begin
            e_r = exp_r.pop_front();
            total++;
            if (ri >= obs_r.size()) begin bad++; $display("FAIL skip_rsp: missing, required rsp=%b data=%h", e_r.vec, e_r.d); end
            else begin
                o_r = obs_r[ri];
                ri++;
                if (o_r.vec !== e_r.vec || o_r.d !== e_r.d || o_r.e !== e_r.e) begin
                    bad++;
                    $display("FAIL skip_rsp: got rsp=%b data=%h err=%b, required rsp=%b data=%h err=%b", o_r.vec, o_r.d, o_r.e, e_r.vec, e_r.d, e_r.e);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int t0, b;
        do_reset();
        set_req(1, 32'h0B000000, 8'd2, 8'd2, 32'hBAD00001);
        set_req(3, 32'h0C000000, 8'd4, 8'd0, 32'h00000333);
        stuck = 1'b1;
        t0 = cyc;
        req_valid = 4'b0010;
        exp_g.push_back(4'b0010);
        exp_r.push_back('{4'b0010, 32'h0, 1'b1, t0 + 22});
        for (int i = 0; i < 100 && obs_r.size() - ri < 1; i++) step();
        req_valid[3] = 1'b1;
        repeat (5) step();
        total++;
        if (obs_g.size() - gi != 1) begin
            bad++;
            $display("FAIL timeout_drain_hold: got %0d grants while busy stuck, required 1", obs_g.size() - gi);
        end
        stuck = 1'b0;
        for (int i = 0; i < 50 && spi_busy; i++) step();
        b = cyc;
        exp_g.push_back(4'b1000);
        exp_r.push_back('{4'b1000, 32'h00000333, 1'b0, b + 9});
        for (int i = 0; i < 100 && obs_r.size() - ri < 2; i++) step();
        repeat (10) step();
        total++;
        if (obs_g.size() - gi < 2 || obs_g[gi + 1].c != b + 2) begin
            bad++;
            $display("FAIL timeout_regrant: next grant missing or late (%0d grants), required grant at cycle %0d", obs_g.size() - gi, b + 2);
        end
        while (exp_g.size() > 0) begin
            e_g = exp_g.pop_front();
            total++;
            if (gi >= obs_g.size()) begin bad++; $display("FAIL timeout_grant: missing, required %b", e_g); end
            else begin
                if (obs_g[gi].vec !== e_g) begin
                    bad++;
                    $display("FAIL timeout_grant: got ready=%b, required %b", obs_g[gi].vec, e_g);
                end
                gi++;
            end
        end
        while (exp_r.size() > 0) begin
            e_r = exp_r.pop_front();
            total++;
            if (ri >= obs_r.size()) begin bad++; $display("FAIL timeout_rsp: missing, required rsp=%b err=%b", e_r.vec, e_r.e); end
            else begin
                o_r = obs_r[ri];
                ri++;
                if (o_r.vec !== e_r.vec || o_r.d !== e_r.d || o_r.e !== e_r.e || o_r.c != e_r.c) begin
                    bad++;
                    $display("FAIL timeout_rsp: got rsp=%b data=%h err=%b cyc=%0d, required rsp=%b data=%h err=%b cyc=%0d",
                             o_r.vec, o_r.d, o_r.e, o_r.c, e_r.vec, e_r.d, e_r.e, e_r.c);
                end
            end
        end
        total++;
        if (obs_r.size() != ri) begin bad++; $display("FAIL timeout_second_rsp: got %0d extra responses, required 0", obs_r.size() - ri); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(2, 32'h22000000, 8'd8, 8'd8, 32'h00002222);
        set_req(0, 32'h00F00000, 8'd1, 8'd1, 32'h000000F0);
        set_req(3, 32'h0F300000, 8'd1, 8'd0, 32'h00000F03);
        req_valid = 4'b0100;
        exp_g.push_back(4'b0100);
        for (int i = 0; i < 20 && obs_g.size() - gi < 1; i++) step();
        repeat (3) step();
        reset = 1'b1;
        req_valid = 4'b1001;
        step();
        total++;
        if ({req_ready, rsp_valid, spi_request, spi_sel, spi_data_out, spi_write_bits, spi_read_bits, rsp_data, rsp_error} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got ready=%b rsp=%b req=%b sel=%0d dout=%h wb=%0d rb=%0d rdata=%h err=%b, required all 0",
                     req_ready, rsp_valid, spi_request, spi_sel, spi_data_out, spi_write_bits, spi_read_bits, rsp_data, rsp_error);
        end
        reset = 1'b0;
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b1000);
        exp_r.push_back('{4'b0001, 32'h000000F0, 1'b0, -1});
        exp_r.push_back('{4'b1000, 32'h00000F03, 1'b0, -1});
        for (int i = 0; i < 100 && obs_r.size() - ri < 2; i++) step();
        repeat (10) step();
        while (exp_g.size() > 0) begin
            e_g = exp_g.pop_front();
            total++;
            if (gi >= obs_g.size()) begin bad++; $display("FAIL midreset_grant: missing, required %b", e_g); end
            else begin
                if (obs_g[gi].vec !== e_g) begin
                    bad++;
                    $display("FAIL midreset_grant: got ready=%b, required %b", obs_g[gi].vec, e_g);
                end
                gi++;
            end
        end
        while (exp_r.size() > 0) begin
            e_r = exp_r.pop_front();
            total++;
            if (ri >= obs_r.size()) begin bad++; $display("FAIL midreset_rsp: missing, required rsp=%b", e_r.vec); end
            else begin
                o_r = obs_r[ri];
                ri++;
                if (o_r.vec !== e_r.vec || o_r.d !== e_r.d || o_r.e !== e_r.e) begin
                    bad++;
                    $display("FAIL midreset_rsp: got rsp=%b data=%h err=%b, required rsp=%b data=%h err=%b", o_r.vec, o_r.d, o_r.e, e_r.vec, e_r.d, e_r.e);
                end
            end
        end
        total++;
        if (obs_r.size() != ri) begin bad++; $display("FAIL midreset_extra_rsp: got %0d extra responses, required 0", obs_r.size() - ri); end
    endtask

    task automatic test_zero_len();
        int t0;
        do_reset();
        set_req(1, 32'h00000000, 8'd0, 8'd0, 32'h00005A5A);
        t0 = cyc;
        req_valid = 4'b0010;
        exp_g.push_back(4'b0010);
        exp_r.push_back('{4'b0010, 32'h00005A5A, 1'b0, t0 + 4});
        for (int i = 0; i < 50 && obs_r.size() - ri < 1; i++) step();
        repeat (5) step();
        while (exp_g.size() > 0) begin
            e_g = exp_g.pop_front();
            total++;
            if (gi >= obs_g.size()) begin bad++; $display("FAIL zero_grant: missing, required %b", e_g); end
            else begin
                if (obs_g[gi].vec !== e_g || obs_g[gi].wb !== 8'd0 || obs_g[gi].rb !== 8'd0 || obs_g[gi].c != t0 + 1) begin
                    bad++;
                    $display("FAIL zero_grant: got ready=%b wb=%0d rb=%0d cyc=%0d, required ready=%b wb=0 rb=0 cyc=%0d",
                             obs_g[gi].vec, obs_g[gi].wb, obs_g[gi].rb, obs_g[gi].c, e_g, t0 + 1);
                end
                gi++;
            end
        end
        while (exp_r.size() > 0) begin
            e_r = exp_r.pop_front();
            total++;
            if (ri >= obs_r.size()) begin bad++; $display("FAIL zero_rsp: missing, required rsp=%b", e_r.vec); end
            else begin
                o_r = obs_r[ri];
                ri++;
                if (o_r.vec !== e_r.vec || o_r.d !== e_r.d || o_r.e !== e_r.e || o_r.c != e_r.c) begin
                    bad++;
                    $display("FAIL zero_rsp: got rsp=%b data=%h err=%b cyc=%0d, required rsp=%b data=%h err=%b cyc=%0d",
                             o_r.vec, o_r.d, o_r.e, o_r.c, e_r.vec, e_r.d, e_r.e, e_r.c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_skip();
        test_timeout();
        test_reset_mid();
        test_zero_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and sequencer sharing one `spi_interface` instance between NUM_REQ independent requesters, such as the ADC configuration and clock-chip configuration blocks. Each requester presents a fully formatted SPI transaction. The arbiter grants one requester at a time, issues a single `request_action` pulse, waits for the transaction to complete, and returns the read-back word with a one-cycle response strobe. A watchdog reports transactions whose `busy` signal never falls.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- SELW, 2, width of the index signals; must equal ceil(log2(NUM_REQ)).
- TIMEOUT, 65535, watchdog limit in clk cycles (16-bit); 0 disables the watchdog.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester transaction request; held until the matching req_ready.
- req_data_out  in  32*NUM_REQ  per-requester SPI word; slice i = [32*i+31:32*i].
- req_write_bits  in  8*NUM_REQ  per-requester count of bits to write.
- req_read_bits  in  8*NUM_REQ  per-requester count of bits to read.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_data  out  32  read-back word; valid only while any rsp_valid bit is high.
- rsp_error  out  1  watchdog flag; qualified by rsp_valid.
- spi_sel  out  SELW  index of the current owner, for external cs/sdio routing.
- spi_data_out  out  32  to spi_interface.data_out.
- spi_write_bits  out  8  to spi_interface.write_bits.
- spi_read_bits  out  8  to spi_interface.read_bits.
- spi_request  out  1  to spi_interface.request_action.
- spi_busy  in  1  from spi_interface.busy.
- spi_data_in  in  32  from spi_interface.data_in; nonzero only in the completion cycle.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE: if any req_valid is set, select the first set bit searching upward from pointer `rr` with wrap-around.
  - Latch that requester's data_out, write_bits and read_bits into the spi_* registers.
  - Latch its index into spi_sel and the owner register.
  - Go to ISSUE.
- ISSUE: assert spi_request for exactly one cycle and req_ready[owner] for the same cycle. Set rr = (owner+1) mod NUM_REQ. Clear the watchdog counter. Go to WAIT.
- WAIT: spi_request = 0.
  - If spi_busy = 0: capture spi_data_in into rsp_data, clear rsp_error, pulse rsp_valid[owner] in the next cycle, and go to IDLE.
  - Else if TIMEOUT != 0 and the counter equals TIMEOUT-1: set rsp_data = 0, rsp_error = 1, pulse rsp_valid[owner] in the next cycle, and go to DRAIN.
  - Otherwise increment the counter; it saturates and does not wrap.
- DRAIN: wait for spi_busy = 0, discard spi_data_in with no second response, then go to IDLE.
- Zero-length transactions (write_bits + read_bits = 0) take the normal path with no special case.
- spi_data_out, spi_write_bits, spi_read_bits and spi_sel hold stable from ISSUE through the end of WAIT/DRAIN.
- A requester whose req_valid drops before its req_ready is simply not granted. The requester must not do this while its slice is latched. Its fields are sampled on the IDLE edge and must stay stable through the req_ready cycle.

## Timing
- Reset values: all outputs 0, state IDLE, rr = 0, counter 0.
- Reset mid-transaction: immediate return to IDLE; no rsp_valid is issued for the aborted transaction. spi_interface shares the same reset.
- Request to spi_request latency: req_valid sampled high in IDLE at edge N gives spi_request and req_ready high during cycle N+1 (ISSUE).
- Completion: spi_busy is first low in WAIT cycle M. rsp_valid and rsp_data are high during cycle M+1, which is the first cycle of IDLE.
- Minimum spacing between consecutive spi_request pulses is 3 cycles plus the SPI transaction length, as IDLE always lasts at least one cycle.
- In the first WAIT cycle spi_busy is already high, because busy_int is set on the edge that ends ISSUE.
- Simultaneous requests: exactly one grant per arbitration. A requester that is not granted keeps req_valid asserted and wins within NUM_REQ-1 further grants.
- rsp_valid for transaction k always precedes req_ready for transaction k+1.

## Test plan
- Single request: requester 2 sends data_out 0x8A000000, write_bits 8, read_bits 8, with the SPI model returning 0x000000A5. Expect req_ready = 4'b0100, one spi_request pulse, spi_sel = 2, then rsp_valid = 4'b0100, rsp_data = 0x000000A5, rsp_error = 0.
- All four requesters valid from reset. Expect grant order 0,1,2,3,0 and exactly one spi_request per grant.
- Requesters 1 and 3 valid after a grant to 1. Expect the next grant to go to 3 (rr = 2 skips the invalid requester 2), then 1.
- TIMEOUT = 20 with spi_busy stuck high. Expect rsp_valid with rsp_error = 1 and rsp_data = 0 on the 21st cycle after ISSUE. A later release of busy causes no second response and no new grant until IDLE.
- Reset asserted in WAIT. Expect all outputs 0 the next cycle, rr = 0, and no rsp_valid. After reset is released, a pending req_valid[0] is granted first.
- write_bits = 0, read_bits = 0. Expect normal completion with rsp_valid and no hang.
